spatz_decoder_fifo: RTL and testbench
=====================================

// Module: spatz_decoder_fifo
// PURPOSE
// Buffered, flow-controlled vector instruction decoder between the accelerator request interface and the Spatz controller.
// - Accepts offloaded instructions (valid/ready), decodes each with the combinational decode rules (decoder_req_t -> spatz_req_t + illegal flag).
// - Queues decoded results in an in-order FIFO of parametrised depth, with a transaction ID per entry.
// - Blocks new instructions after a vset{i}vl{i} until the controller acknowledges the new configuration.
// PARAMETERS
// Depth      4   FIFO entries; power of two, >=2
// IdWidth    5   width of transaction ID carried with each instruction
// CntWidth   16  width of saturating illegal-instruction counter
// PORTS
// clk_i            in   1          clock
// rst_ni           in   1          asynchronous active-low reset
// req_valid_i      in   1          instruction offered
// req_ready_o      out  1          instruction accepted when valid&ready
// req_i            in   decoder_req_t  instr, rs1/rs1_valid, rs2/rs2_valid
// req_id_i         in   IdWidth    transaction ID
// rsp_valid_o      out  1          head entry valid
// rsp_ready_i      in   1          head entry consumed when valid&ready
// rsp_spatz_req_o  out  spatz_req_t decoded request of head entry
// rsp_illegal_o    out  1          head entry is illegal
// rsp_id_o         out  IdWidth    ID of head entry
// cfg_done_i       in   1          controller pulse: pending VCFG has been applied
// flush_i          in   1          drop all queued entries, leave config-wait
// outstanding_o    out  $clog2(Depth+1) current FIFO occupancy
// illegal_cnt_o    out  CntWidth   saturating count of accepted illegal instructions
// BEHAVIOUR
// - Reset: FIFO empty, state RUN, rsp_valid_o=0, req_ready_o=1 after reset release, outstanding_o=0, illegal_cnt_o=0; rsp_* data outputs '0.
// - Decode: combinational on req_i; spatz_req_t and illegal flag stored unmodified alongside req_id_i; illegal entries are still enqueued.
// - req_ready_o = (state==RUN) & (count<Depth) & ~flush_i; no dependency on rsp_ready_i, so a full FIFO stays not-ready in the cycle it is popped.
// - Latency: accept in cycle N -> entry visible at head by N+1 if FIFO was empty; strict in-order.
// - Push and pop in the same cycle: count unchanged; pop of last entry with a push -> rsp_valid_o stays 1 with new entry.
// - Pointers wrap modulo Depth; count distinguishes full from empty.
// - rsp_* outputs stable while rsp_valid_o=1 & ~rsp_ready_i.
// FSM
// - RUN -> CFG_WAIT: when an accepted instruction decodes legal with op==VCFG.
// - CFG_WAIT -> RUN: cfg_done_i=1; accepting resumes the following cycle.
// - In CFG_WAIT req_ready_o=0; the VCFG entry itself still drains normally.
// - cfg_done_i in RUN is ignored.
// - flush_i (highest priority):
//   - Empties the FIFO, forces RUN, blocks push that cycle; an offered request is not accepted.
//   - rsp_valid_o=0 next cycle.
//   - A pop in the same cycle still completes at the interface.
//   - illegal_cnt_o is not cleared.
// - illegal_cnt_o += 1 per accepted illegal instruction; saturates at all-ones.
// - Reset asserted mid-operation: all state returns to reset values immediately; queued entries are lost.
// TESTING
// - Push vadd.vv 0x02208057, ID 3, rsp_ready_i=1 -> next cycle:
//   - rsp_valid_o=1, op=VADD, vd=0, vs1=1, vs2=2, illegal=0, id=3.
// - rsp_ready_i=0, push 4 legal VADDs -> outstanding_o=4, req_ready_o=0.
//   - Pop one -> ready returns next cycle.
//   - IDs emerge 0,1,2,3 in order.
// - Push vsetvli 0x010572D7 (rs1_valid=1), then a VADD offered continuously:
//   - req_ready_o=0 until cfg_done_i pulses at cycle 10.
//   - VADD accepted cycle 11.
// - Push 0x00000013 (addi) -> entry with illegal=1, FSM stays RUN, illegal_cnt_o=1.
//   - Preload counter path to 0xFFFF -> stays 0xFFFF.
// - Queue 3 entries, assert flush_i with req_valid_i=1 -> next cycle:
//   - outstanding_o=0, rsp_valid_o=0, offered request not accepted.
// - Assert flush_i in CFG_WAIT -> state RUN, req_ready_o=1 next cycle.
//   - Reset mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/spatz_decoder_fifo.sv
// Buffered vector instruction decoder.
// Decodes offloaded instructions into spatz_req_t plus an illegal flag and queues them, with their
// transaction ID, in an in-order FIFO toward the Spatz controller. After a legal vset{i}vl{i}, new
// instructions are held off until the controller signals that the configuration has been applied.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          instruction handshake
//   req_i, req_id_i                  instruction with scalar operands, transaction ID
//   rsp_valid_o/rsp_ready_i          head-entry handshake
//   rsp_spatz_req_o, rsp_illegal_o   decoded head entry
//   rsp_id_o                         ID of the head entry
//   cfg_done_i                       pending VCFG has been applied
//   flush_i                          drop queued entries and leave config-wait
//   outstanding_o                    FIFO occupancy
//   illegal_cnt_o                    saturating count of accepted illegal instructions

package spatz_decoder_pkg;

  typedef enum logic [1:0] {OpNone, OpVcfg, OpVadd, OpVsub} op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic        rs1_valid;
    logic [31:0] rs2;
    logic        rs2_valid;
  } decoder_req_t;

  typedef struct packed {
    op_e         op;
    logic        vm;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [10:0] vtype;
  } spatz_req_t;

endpackage

module spatz_decoder_fifo
  import spatz_decoder_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdWidth  = 5,
  parameter int unsigned CntWidth = 16,
  localparam int unsigned OccW    = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  decoder_req_t        req_i,
  input  logic [IdWidth-1:0]  req_id_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output spatz_req_t          rsp_spatz_req_o,
  output logic                rsp_illegal_o,
  output logic [IdWidth-1:0]  rsp_id_o,
  input  logic                cfg_done_i,
  input  logic                flush_i,
  output logic [OccW-1:0]     outstanding_o,
  output logic [CntWidth-1:0] illegal_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  typedef enum logic [0:0] {StRun, StCfgWait} state_e;

  typedef struct packed {
    spatz_req_t         req;
    logic               illegal;
    logic [IdWidth-1:0] id;
  } entry_t;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]     count_q, count_d;
  logic [CntWidth-1:0] illegal_cnt_q, illegal_cnt_d;
  entry_t              mem_q [Depth];

  spatz_req_t dec_req;
  logic       dec_illegal;
  logic       push, pop;

  // Decode: register fields are always extracted; op stays OpNone unless the encoding is legal.
  always_comb begin
    logic [31:0] instr;
    instr       = req_i.instr;
    dec_req     = '0;
    dec_illegal = 1'b1;
    dec_req.vm  = instr[25];
    dec_req.vd  = instr[11:7];
    dec_req.vs1 = instr[19:15];
    dec_req.vs2 = instr[24:20];
    dec_req.rs1 = req_i.rs1;
    dec_req.rs2 = req_i.rs2;
    if (instr[6:0] == 7'b1010111) begin
      case (instr[14:12])
        3'b111: begin
          if (!instr[31]) begin
            // vsetvli: rs1=x0 needs no scalar operand
            if (req_i.rs1_valid || instr[19:15] == 5'd0) begin
              dec_req.op    = OpVcfg;
              dec_req.vtype = instr[30:20];
              dec_illegal   = 1'b0;
            end
          end else if (instr[31:30] == 2'b11) begin
            // vsetivli: AVL is the immediate in the vs1 field
            dec_req.op    = OpVcfg;
            dec_req.vtype = {1'b0, instr[29:20]};
            dec_illegal   = 1'b0;
          end else if (instr[31:25] == 7'b1000000 && req_i.rs2_valid) begin
            dec_req.op    = OpVcfg;
            dec_req.vtype = req_i.rs2[10:0];
            dec_illegal   = 1'b0;
          end
        end
        3'b000: begin
          if (instr[31:26] == 6'b000000) begin
            dec_req.op  = OpVadd;
            dec_illegal = 1'b0;
          end else if (instr[31:26] == 6'b000010) begin
            dec_req.op  = OpVsub;
            dec_illegal = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state_q == StRun) && (count_q < OccW'(Depth)) && !flush_i;
  assign rsp_valid_o = (count_q != '0);
  assign push        = req_valid_i && req_ready_o;
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase

    if (push && dec_illegal && illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + 1'b1;

    unique case (state_q)
      StRun:     if (push && !dec_illegal && dec_req.op == OpVcfg) state_d = StCfgWait;
      StCfgWait: if (cfg_done_i) state_d = StRun;
      default:   state_d = StRun;
    endcase

    // Flush wins over everything; push is already blocked through req_ready_o.
    if (flush_i) begin
      state_d  = StRun;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StRun;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{req: dec_req, illegal: dec_illegal, id: req_id_i};
  end

  always_comb begin
    rsp_spatz_req_o = '0;
    rsp_illegal_o   = 1'b0;
    rsp_id_o        = '0;
    if (rsp_valid_o) begin
      rsp_spatz_req_o = mem_q[rd_ptr_q].req;
      rsp_illegal_o   = mem_q[rd_ptr_q].illegal;
      rsp_id_o        = mem_q[rd_ptr_q].id;
    end
  end

  assign outstanding_o = count_q;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_spatz_decoder_fifo.sv
module tb_spatz_decoder_fifo;
  import spatz_decoder_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  decoder_req_t      req_i;
  logic [4:0]        req_id_i, rsp_id_o;
  spatz_req_t        rsp_spatz_req_o;
  logic              rsp_illegal_o, cfg_done_i, flush_i;
  logic [2:0]        outstanding_o;
  logic [15:0]       illegal_cnt_o;

  always #5 clk_i = ~clk_i;

  spatz_decoder_fifo #(.Depth(4), .IdWidth(5), .CntWidth(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_i          (req_i),
    .req_id_i       (req_id_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_spatz_req_o(rsp_spatz_req_o),
    .rsp_illegal_o  (rsp_illegal_o),
    .rsp_id_o       (rsp_id_o),
    .cfg_done_i     (cfg_done_i),
    .flush_i        (flush_i),
    .outstanding_o  (outstanding_o),
    .illegal_cnt_o  (illegal_cnt_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic        rs1_valid;
    logic [4:0]  id;
    op_e         op;
    logic [4:0]  vd, vs1, vs2;
    logic        ill;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  cur_exp;
  vec_t  sb_q[$];
  vec_t  vecs[6];
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic rv, input logic [4:0] id,
                              input op_e op, input logic [4:0] vd, input logic [4:0] vs1,
                              input logic [4:0] vs2, input logic ill);
    vec_t v;
    v.instr = instr; v.rs1_valid = rv; v.id = id; v.op = op;
    v.vd = vd; v.vs1 = vs1; v.vs2 = vs2; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t vadd(input logic [4:0] id);
    return mk(32'h02208057, 1'b0, id, OpVadd, 5'd0, 5'd1, 5'd2, 1'b0);
  endfunction

  function automatic vec_t vcfg(input logic [4:0] id);
    return mk(32'h010572D7, 1'b1, id, OpVcfg, 5'd5, 5'd10, 5'd16, 1'b0);
  endfunction

  task automatic set_req(input vec_t v);
    req_i           = '0;
    req_i.instr     = v.instr;
    req_i.rs1       = 32'h0000_0040;
    req_i.rs1_valid = v.rs1_valid;
    req_id_i        = v.id;
    cur_exp         = v;
    req_valid_i     = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // Scoreboard: expectations enter on accept, leave on pop; flush drops what is left after a pop.
  always @(negedge clk_i) begin
    if (rst_n) begin
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_rsp actual_id=%0d expected=none", rsp_id_o);
        end else begin
          vec_t e;
          e = sb_q.pop_front();
          chk("rsp_entry",
              64'({rsp_spatz_req_o.op, rsp_spatz_req_o.vd, rsp_spatz_req_o.vs1,
                   rsp_spatz_req_o.vs2, rsp_illegal_o, rsp_id_o}),
              64'({e.op, e.vd, e.vs1, e.vs2, e.ill, e.id}));
        end
      end
      if (flush_i) sb_q.delete();
      if (req_valid_i && req_ready_o) begin
        sb_q.push_back(cur_exp);
        if (cur_exp.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  always @(negedge rst_n) begin
    sb_q.delete();
    exp_cnt = '0;
  end

  initial begin
    vecs[0] = mk(32'h02208057, 1'b0, 5'd3, OpVadd, 5'd0, 5'd1, 5'd2, 1'b0);
    vecs[1] = mk(32'h0A208057, 1'b0, 5'd4, OpVsub, 5'd0, 5'd1, 5'd2, 1'b0);
    vecs[2] = mk(32'h025201D7, 1'b0, 5'd5, OpVadd, 5'd3, 5'd4, 5'd5, 1'b0);
    vecs[3] = mk(32'h00000013, 1'b0, 5'd6, OpNone, 5'd0, 5'd0, 5'd0, 1'b1);
    vecs[4] = mk(32'hFE208057, 1'b0, 5'd7, OpNone, 5'd0, 5'd1, 5'd2, 1'b1);
    vecs[5] = mk(32'h0220A057, 1'b0, 5'd8, OpNone, 5'd0, 5'd1, 5'd2, 1'b1);

    req_valid_i = 1'b0; req_i = '0; req_id_i = '0; rsp_ready_i = 1'b0;
    cfg_done_i = 1'b0; flush_i = 1'b0; cur_exp = vadd(5'd0);

    // Reset state
    repeat (2) @(posedge clk_i);
    smp();
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_illegal_cnt", 64'(illegal_cnt_o), 64'd0);
    chk("rst_data_zero", 64'(rsp_spatz_req_o == '0 && rsp_id_o == '0 && !rsp_illegal_o), 64'd1);
    tick();
    rst_n = 1'b1;
    smp();
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    tick();

    // Table-driven decode: one instruction per slot, visible at head the next cycle
    rsp_ready_i = 1'b1;
    foreach (vecs[i]) begin
      set_req(vecs[i]);
      tick();
      req_valid_i = 1'b0;
      smp();
      chk("latency_valid", 64'(rsp_valid_o), 64'd1);
      chk("run_ready", 64'(req_ready_o), 64'd1);
      tick();
    end
    smp();
    chk("illegal_cnt_table", 64'(illegal_cnt_o), 64'(exp_cnt));
    chk("illegal_cnt_three", 64'(illegal_cnt_o), 64'd3);
    tick();

    // Fill to full; a pop while full does not raise ready in the same cycle
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(vadd(5'(i)));
      tick();
    end
    set_req(vadd(5'd4));
    smp();
    chk("full_outstanding", 64'(outstanding_o), 64'd4);
    chk("full_ready", 64'(req_ready_o), 64'd0);
    tick();
    rsp_ready_i = 1'b1;
    smp();
    chk("full_pop_ready", 64'(req_ready_o), 64'd0);
    tick();
    rsp_ready_i = 1'b0;
    smp();
    chk("after_pop_ready", 64'(req_ready_o), 64'd1);
    chk("after_pop_outstanding", 64'(outstanding_o), 64'd3);
    tick();
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (6) tick();
    smp();
    chk("drain_outstanding", 64'(outstanding_o), 64'd0);
    tick();

    // vsetvli blocks accepts until cfg_done_i
    set_req(vcfg(5'd7));
    tick();
    set_req(vadd(5'd8));
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("cfg_wait_ready", 64'(req_ready_o), 64'd0);
      tick();
    end
    cfg_done_i = 1'b1;
    smp();
    chk("cfg_done_cycle_ready", 64'(req_ready_o), 64'd0);
    tick();
    cfg_done_i = 1'b0;
    smp();
    chk("cfg_resume_ready", 64'(req_ready_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    repeat (2) tick();
    smp();
    chk("cfg_drained", 64'(outstanding_o), 64'd0);
    tick();

    // Saturation of the illegal counter with a continuous illegal stream
    set_req(mk(32'h00000013, 1'b0, 5'd9, OpNone, 5'd0, 5'd0, 5'd0, 1'b1));
    repeat (65540) tick();
    req_valid_i = 1'b0;
    repeat (2) tick();
    smp();
    chk("illegal_cnt_model", 64'(illegal_cnt_o), 64'(exp_cnt));
    chk("illegal_cnt_sat", 64'(illegal_cnt_o), 64'hFFFF);
    tick();

    // Flush with three queued, a request offered and a pop in the same cycle
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(vadd(5'(10 + i)));
      tick();
    end
    set_req(vadd(5'd20));
    flush_i = 1'b1;
    rsp_ready_i = 1'b1;
    smp();
    chk("flush_ready", 64'(req_ready_o), 64'd0);
    chk("flush_pre_outstanding", 64'(outstanding_o), 64'd3);
    tick();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    smp();
    chk("flush_outstanding", 64'(outstanding_o), 64'd0);
    chk("flush_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("flush_keeps_cnt", 64'(illegal_cnt_o), 64'hFFFF);
    tick();

    // Flush while in config-wait
    set_req(vcfg(5'd9));
    tick();
    req_valid_i = 1'b0;
    smp();
    chk("cfgwait_ready", 64'(req_ready_o), 64'd0);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    smp();
    chk("flush_cfg_ready", 64'(req_ready_o), 64'd1);
    chk("flush_cfg_outstanding", 64'(outstanding_o), 64'd0);
    tick();

    // Asynchronous reset mid-stream
    set_req(vadd(5'd1));
    repeat (2) tick();
    req_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("midrst_outstanding", 64'(outstanding_o), 64'd0);
    chk("midrst_illegal_cnt", 64'(illegal_cnt_o), 64'd0);
    chk("midrst_data_zero", 64'(rsp_spatz_req_o == '0 && rsp_id_o == '0), 64'd1);
    tick();
    rst_n = 1'b1;
    smp();
    chk("midrst_ready", 64'(req_ready_o), 64'd1);
    chk("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
